xtea_stream_ctrl: RTL
=====================

Name: xtea_stream_ctrl

Overview:
- Word-stream front end for the 128-bit XTEA encoder core; sits directly around it.
- Packs four 32-bit input words into a 128-bit block and holds the key stable for the block.
- Sequences the encoder's enable/done contract, captures the ciphertext and drains it as four 32-bit words.
- Uses valid/ready handshakes on both stream sides; one block in flight, no overlap.

Parameters:
TIMEOUT_CYC, 255, max RUN-state cycles waiting for enc_done before declaring a fault (8-bit counter; 2..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
key_in  input  128  encryption key, sampled when the 4th input word is accepted
in_valid  input  1  input word valid
in_ready  output  1  controller can accept a word
in_data  input  32  plaintext word
out_valid  output  1  ciphertext word valid
out_ready  input  1  sink accepts word
out_data  output  32  ciphertext word
enc_enable  output  1  enable to encoder core
enc_data_in  output  128  plaintext block to encoder
enc_key  output  128  latched key to encoder
enc_data_out  input  128  ciphertext block from encoder
enc_done  input  1  encoder completion flag
busy  output  1  high in any state other than FILL
timeout_err  output  1  sticky fault flag, cleared only by reset

Behaviour:
- Reset, asynchronous:
  - State FILL; word index 0; cycle counter 0; first flag 0.
  - in_ready=1, out_valid=0, enc_enable=0, timeout_err=0.
  - All data registers 0, so out_data=0, enc_data_in=0, enc_key=0.
- Encoder contract this block relies on:
  - On the first enabled edge while idle, the core loads enc_data_in/enc_key and clears done.
  - It needs 64 further enabled edges, then asserts done together with valid enc_data_out.
  - done stays high until the next load.
  - An enabled edge while done=1 triggers a reload, so enable must drop combinationally when done is seen.
- FILL:
  - in_ready=1. Word accepted on an edge with in_valid&in_ready.
  - Word k (k=0..3) goes to block bits [32k+31:32k].
  - On accepting word 3: latch key_in into enc_key, clear index, go START.
- START (1 cycle):
  - enc_enable=1, regardless of the stale enc_done from the previous block.
  - Core loads the block. Clear cycle counter, go RUN.
- RUN:
  - enc_enable = ~enc_done (combinational).
  - Counter increments each cycle.
  - On enc_done=1: capture enc_data_out into the output buffer, go DRAIN. Nominal RUN length is 65 cycles.
  - If the counter reaches TIMEOUT_CYC with enc_done=0: set timeout_err, drop enc_enable, discard the block, go FILL.
- DRAIN:
  - out_valid=1; out_data = buffer word[idx], low word first.
  - Index advances on out_valid&out_ready.
  - After word 3 is accepted: index 0, go FILL.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- in_ready=0 in START/RUN/DRAIN; input words presented then are not consumed.
- out_valid=0 outside DRAIN.
- End-to-end latency:
  - 4th input accept → first out_valid = 1 (START) + 65 (RUN) = 66 cycles.
  - Zero input/output stalls → 74 cycles per block minimum.
- Simultaneous in_valid during DRAIN is ignored. No input bubbles are required between blocks.
- Reset mid-operation (any state) returns to FILL and discards partial input and output data. The encoder core is reset by the same signal.
- key_in changes after the 4th accept have no effect on the current block.

Test Plan:
- Reset, then push words 0x00000000 ×4 with key 0 → enc_data_in=0 during START; out words match the golden XTEA-variant model (32 cycles, delta 0x9E3779B9) in order [31:0]..[127:96]; first out_valid exactly 66 cycles after 4th accept.
- Two back-to-back blocks (0x01234567,0x89ABCDEF,0xFEDCBA98,0x76543210 then 0xDEADBEEF×4), key 0x000102..0F → second block is correctly encrypted (proves stale done does not block START); enc_enable is 0 in every cycle enc_done=1.
- Random out_ready backpressure (50%) → out_data is held while stalled; all 4 words are delivered exactly once; in_ready stays 0 until the last word is drained.
- Core model that never asserts done, TIMEOUT_CYC=20 → timeout_err=1 after 20 RUN cycles, state returns to FILL with in_ready=1, and no out_valid.
- Assert reset during RUN (cycle 30) → outputs return to their reset values immediately; a new full block afterwards encrypts correctly.
- Change key_in between the 4th accept and done → ciphertext matches the key latched at the 4th accept.

Source files
------------

// File: rtl/xtea_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : xtea_stream_ctrl
//  Description : Word-stream front end for a 128-bit XTEA encoder core.
//                Packs four 32-bit plaintext words into one block, latches
//                the key when the block is complete, runs the encoder's
//                enable/done handshake and drains the ciphertext as four
//                32-bit words, low word first. One block is in flight at a
//                time. A RUN phase that outlasts TIMEOUT_CYC cycles without
//                done discards the block and raises a sticky fault flag.
//
//  Ports       : clock, reset     - rising-edge clock, async active-high reset
//                key_in           - key, sampled with the 4th input word
//                in_valid/in_ready/in_data    - plaintext word stream
//                out_valid/out_ready/out_data - ciphertext word stream
//                enc_enable, enc_data_in, enc_key - drive the encoder core
//                enc_data_out, enc_done           - results from the core
//                busy             - high in any state other than FILL
//                timeout_err      - sticky fault, cleared only by reset
//
//  Revision    : 1.0 - initial release
// ============================================================================
module xtea_stream_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         enc_enable,
    output logic [127:0] enc_data_in,
    output logic [127:0] enc_key,
    input  logic [127:0] enc_data_out,
    input  logic         enc_done,
    output logic         busy,
    output logic         timeout_err
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Counter value seen on the last RUN cycle allowed before a fault.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]   r_state;
    logic [1:0]   r_idx;        // word index, shared by FILL and DRAIN
    logic [7:0]   r_cnt;        // RUN-state cycle counter
    logic         r_first;      // a block has been loaded and is being run
    logic [127:0] r_block;
    logic [127:0] r_key;
    logic [127:0] r_obuf;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;
    logic         r_timeout_err;

    logic         w_in_fire;
    logic         w_out_fire;
    logic [6:0]   w_word_lsb;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_word_lsb = {r_idx, 5'd0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_FILL;
            r_idx         <= 2'd0;
            r_cnt         <= 8'd0;
            r_first       <= 1'b0;
            r_block       <= '0;
            r_key         <= '0;
            r_obuf        <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        r_block[w_word_lsb +: 32] <= in_data;
                        if (r_idx == 2'd3) begin
                            r_key      <= key_in;
                            r_idx      <= 2'd0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_START;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end

                // The core loads on this edge; any done left over from the
                // previous block is cleared by the load itself.
                S_START: begin
                    r_cnt   <= 8'd0;
                    r_first <= 1'b1;
                    r_state <= S_RUN;
                end

                S_RUN: begin
                    if (enc_done) begin
                        r_obuf      <= enc_data_out;
                        r_first     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_first       <= 1'b0;
                        r_block       <= '0;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_FILL;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_idx == 2'd3) begin
                            r_idx       <= 2'd0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_FILL;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    // Enable must fall in the same cycle done is seen, otherwise the core
    // would take the next edge as a reload of the block.
    assign enc_enable  = (r_state == S_START) |
                         ((r_state == S_RUN) & r_first & ~enc_done);

    assign enc_data_in = r_block;
    assign enc_key     = r_key;
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_obuf[w_word_lsb +: 32];
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
